// File: rtl/if_stage.sv
// Instruction-fetch stage: direct-mapped one-word-per-line I-cache with a miss FSM
// toward the memory controller, plus the IF/ID pipeline register feeding decode.
module if_stage #(
    parameter int          ICACHE_IDX_W = 6,
    parameter logic [31:0] NOP_INST     = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic [5:0]  stall_state,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stallreq_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o
);

    localparam int LINES = 1 << ICACHE_IDX_W;
    localparam int TAG_W = 30 - ICACHE_IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                    state_r, state_s;
    logic                      mem_req_r, mem_req_s;
    logic [31:0]               mem_addr_r, mem_addr_s;
    logic                      fill_s;
    logic [LINES-1:0]          line_valid_r;
    logic [TAG_W-1:0]          tag_mem_r  [LINES];
    logic [31:0]               data_mem_r [LINES];
    logic [ICACHE_IDX_W-1:0]   idx_s, fill_idx_s;
    logic [TAG_W-1:0]          tag_s, fill_tag_s;
    logic                      hit_s;
    logic                      stallreq_s;
    logic [31:0]               if_pc_r, if_pc_s;
    logic [31:0]               if_inst_r, if_inst_s;
    logic                      if_valid_r, if_valid_s;
    logic                      unused_s;

    assign idx_s      = pc_i[ICACHE_IDX_W+1:2];
    assign tag_s      = pc_i[31:ICACHE_IDX_W+2];
    assign fill_idx_s = mem_addr_r[ICACHE_IDX_W+1:2];
    assign fill_tag_s = mem_addr_r[31:ICACHE_IDX_W+2];
    assign hit_s      = line_valid_r[idx_s] && (tag_mem_r[idx_s] == tag_s);
    assign stallreq_s = (state_r != ST_IDLE) || !hit_s;
    assign unused_s   = ^{pc_i[1:0], stall_state[5:2], stall_state[0]};

    assign stallreq_o = stallreq_s;
    assign mem_req_o  = mem_req_r;
    assign mem_addr_o = mem_addr_r;
    assign if_pc_o    = if_pc_r;
    assign if_inst_o  = if_inst_r;
    assign if_valid_o = if_valid_r;

    // Miss FSM next state, request/address next values and fill strobe.
    always_comb begin
        state_s    = state_r;
        mem_req_s  = mem_req_r;
        mem_addr_s = mem_addr_r;
        fill_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!hit_s && !flush_i) begin
                    state_s    = ST_WAIT;
                    mem_req_s  = 1'b1;
                    mem_addr_s = {pc_i[31:2], 2'b00};
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A fill arriving together with a flush still lands; the line is correct.
                if (mem_valid_i) begin
                    fill_s    = 1'b1;
                    mem_req_s = 1'b0;
                    state_s   = ST_IDLE;
                end else if (flush_i) begin
                    state_s   = ST_DROP;
                end else begin
                    state_s   = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (mem_valid_i) begin
                    fill_s    = 1'b1;
                    mem_req_s = 1'b0;
                    state_s   = ST_IDLE;
                end else begin
                    state_s   = ST_DROP;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                mem_req_s = 1'b0;
            end
        endcase
    end

    // IF/ID next value: flush beats stall-hold, which beats the miss bubble.
    always_comb begin
        if_pc_s    = if_pc_r;
        if_inst_s  = if_inst_r;
        if_valid_s = if_valid_r;
        if (flush_i) begin
            if_pc_s    = 32'h0000_0000;
            if_inst_s  = NOP_INST;
            if_valid_s = 1'b0;
        end else if (stall_state[1]) begin
            if_pc_s    = if_pc_r;
            if_inst_s  = if_inst_r;
            if_valid_s = if_valid_r;
        end else if (stallreq_s) begin
            if_pc_s    = 32'h0000_0000;
            if_inst_s  = NOP_INST;
            if_valid_s = 1'b0;
        end else begin
            if_pc_s    = pc_i;
            if_inst_s  = data_mem_r[idx_s];
            if_valid_s = 1'b1;
        end
    end

    // Control state, request registers, line valid bits and IF/ID register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= 32'h0000_0000;
            line_valid_r <= '0;
            if_pc_r      <= 32'h0000_0000;
            if_inst_r    <= NOP_INST;
            if_valid_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            mem_req_r  <= mem_req_s;
            mem_addr_r <= mem_addr_s;
            if (fill_s) begin
                line_valid_r[fill_idx_s] <= 1'b1;
            end
            if_pc_r    <= if_pc_s;
            if_inst_r  <= if_inst_s;
            if_valid_r <= if_valid_s;
        end
    end

    // Tag and data arrays; contents are only meaningful behind a set valid bit.
    always_ff @(posedge clk) begin
        if (fill_s) begin
            tag_mem_r[fill_idx_s]  <= fill_tag_s;
            data_mem_r[fill_idx_s] <= mem_rdata_i;
        end
    end

endmodule
